pipe_csa_addsub: RTL and testbench
==================================

# pipe_csa_addsub

Parametrised, pipelined carry-select adder/subtractor for the ALU datapath, with a valid/ready handshake on both sides. It computes in0 ± in1 with signed overflow, not-equal and less-than flags over a configurable width, split into carry-select slices across a configurable number of register stages. It is the next-generation replacement for the fixed 32-bit combinational carry-select adder. It lets the execute stage trade latency for clock frequency and handles backpressure from the writeback path.

## Interface
Parameters:
- WIDTH, 32, operand/result width; multiple of BLOCK.
- BLOCK, 8, carry-select slice width in bits.
- STAGES, 2, register stages (latency); 1..WIDTH/BLOCK; (WIDTH/BLOCK) divisible by STAGES.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all pipeline state.
- in_valid  input  1  operands/op valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- in0  input  WIDTH  operand A.
- in1  input  WIDTH  operand B.
- sub  input  1  0 = A+B, 1 = A−B (A + ~B + 1).
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  sum/difference, mod 2^WIDTH.
- carry_out  output  1  carry out of MSB (no-borrow when sub=1).
- overflow  output  1  signed overflow.
- isNotEqual  output  1  out != 0.
- isLessThan  output  1  signed A < B (meaningful when sub=1).

## Operation
- Datapath: operand B is inverted when sub=1, and carry-in is set to sub.
- Each BLOCK-bit slice computes two sums, one for carry-in 0 and one for carry-in 1; the real carry selects between them, in the same way as the existing carry-select adder.
- Stage k (0-based) handles slices k·S..(k+1)·S−1, where S = WIDTH/BLOCK/STAGES.
- Each stage register holds:
  - the stage's valid bit;
  - the completed low result bits;
  - the carry into the next slice;
  - the remaining unprocessed high operand bits (B already conditioned);
  - the original sign bits A[MSB] and B'[MSB].
- The final stage output register feeds out, carry_out and the flags.
- Flags are computed from the final result in the last stage:
  - overflow = (A[MSB]==B'[MSB]) && (out[MSB]!=A[MSB]);
  - isNotEqual = |out;
  - isLessThan = overflow ? A[MSB] : out[MSB].
- Flow control uses a single global advance signal: advance = out_ready || !out_valid.
  - in_ready = advance.
  - On advance, every stage loads from its predecessor and stage 0 loads valid = in_valid.
  - On !advance, all stages hold, including bubbles.
- A transfer happens when in_valid && in_ready at input and out_valid && out_ready at output. Result order equals acceptance order; nothing is dropped or duplicated.

## Timing
- Latency: an operand accepted at edge t has its result on out/out_valid after edge t+STAGES−1 (STAGES register stages, registered outputs).
- Throughput: 1 op/cycle while out_ready=1.
- Reset (synchronous) clears all valid bits, out, carry_out and all flags to 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation discards all in-flight ops; no result emerges for them.
- Reset has priority over simultaneous in_valid.
- Simultaneous accept and emit with out_ready=1 and a full pipe: both transfers occur in the same cycle, with no bubble.
- Stall with out_valid=1 and out_ready=0: out and flags stay stable and in_ready=0 until accepted.
- Bubbles: with in_valid=0 while advancing, a valid=0 slot enters the pipe. Data registers in a bubble slot may hold any value; out is don't-care whenever out_valid=0.
- Wrap-around: 0xFFFF_FFFF+1 gives out=0 and carry_out=1 with no overflow.
- STAGES=1 degenerates to one registered combinational carry-select adder.

## Structure
- Shared package alu_pkg: OP_ADD=1'b0, OP_SUB=1'b1. Elaboration-time legality checks on WIDTH, BLOCK and STAGES: compile-time error on violation.
- Sub-module csa_slice (parameter BLOCK): two ripple-carry adders (cin 0 and 1) plus output/carry mux. It is instantiated WIDTH/BLOCK times via generate.
- Top holds the stage registers, the advance logic and the flag logic.

## Test plan
- WIDTH=32, STAGES=2: add 0x7FFF_FFFF + 0x1 -> out=0x8000_0000, overflow=1, isNotEqual=1, carry_out=0, two cycles after accept.
- Sub 5 − 7 -> out=0xFFFF_FFFE, isLessThan=1, isNotEqual=1, overflow=0, carry_out=0. Sub 9 − 9 -> out=0, isNotEqual=0, isLessThan=0, carry_out=1.
- Sub 0x8000_0000 − 1 -> out=0x7FFF_FFFF, overflow=1, isLessThan=1.
- Backpressure: stream 8 back-to-back ops and hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, out held stable, all 8 results emerge in order.
- Reset mid-flight: assert reset for 1 cycle with 2 ops in the pipe -> next cycle out_valid=0 and all outputs 0; the next accepted op yields the correct result after STAGES cycles.
- Parameter sweep: WIDTH=16 with BLOCK=4 and STAGES ∈ {1,2,4}, random signed operands against a reference model -> all outputs match, latency = STAGES.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and pipe_csa_addsub parameter legality check
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit params_ok(input int width, input int block, input int stages);
    if (block < 1 || width < block || stages < 1) return 1'b0;
    if ((width % block) != 0) return 1'b0;
    if (stages > (width / block)) return 1'b0;
    return ((width / block) % stages) == 0;
  endfunction

endpackage

// File: rtl/csa_slice.sv
// rtl/csa_slice.sv - one carry-select slice: sums for cin=0 and cin=1, selected by the real carry
module csa_slice #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0] sum0;
  logic [BLOCK:0] sum1;

  assign sum0 = {1'b0, a} + {1'b0, b};
  assign sum1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign sum  = cin ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0];
  assign cout = cin ? sum1[BLOCK] : sum0[BLOCK];

endmodule

// File: rtl/pipe_csa_addsub.sv
// rtl/pipe_csa_addsub.sv - pipelined carry-select add/sub with valid/ready flow control
module pipe_csa_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry_out,
  output logic             overflow,
  output logic             isNotEqual,
  output logic             isLessThan
);

  localparam int NSL  = WIDTH / BLOCK;
  localparam int SPS  = NSL / STAGES;
  localparam int LAST = STAGES - 1;

  if (!params_ok(WIDTH, BLOCK, STAGES)) begin : g_bad_params
    $error("pipe_csa_addsub: illegal WIDTH/BLOCK/STAGES combination");
  end

  logic                         adv;
  logic [WIDTH-1:0]             b_cond;
  logic [STAGES-1:0]            v_d, v_q;
  logic [STAGES-1:0]            c_d, c_q;
  logic [STAGES-1:0]            am_d, am_q;
  logic [STAGES-1:0]            bm_d, bm_q;
  logic [STAGES-1:0]            stage_cin;
  logic [STAGES-1:0][WIDTH-1:0] a_d, a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_d, b_q;
  logic [STAGES-1:0][WIDTH-1:0] res_d, res_q;
  logic                         ovf_d, ovf_q;
  logic                         ne_d, ne_q;
  logic                         lt_d, lt_q;
  logic [WIDTH-1:0]             res_fin;

  // One global advance: the whole pipe moves or the whole pipe holds, bubbles included.
  assign adv      = out_ready || !v_q[LAST];
  assign in_ready = adv;
  assign b_cond   = (sub == OP_SUB) ? ~in1 : in1;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_d[k]       = in_valid;
      assign a_d[k]       = in0;
      assign b_d[k]       = b_cond;
      assign am_d[k]      = in0[WIDTH-1];
      assign bm_d[k]      = b_cond[WIDTH-1];
      assign stage_cin[k] = sub;
    end else begin : g_body
      assign v_d[k]       = v_q[k-1];
      assign a_d[k]       = a_q[k-1];
      assign b_d[k]       = b_q[k-1];
      assign am_d[k]      = am_q[k-1];
      assign bm_d[k]      = bm_q[k-1];
      assign stage_cin[k] = c_q[k-1];
    end
  end

  for (genvar i = 0; i < NSL; i++) begin : g_sl
    localparam int K = i / SPS;
    logic             cin;
    logic             cout;
    logic [BLOCK-1:0] sum;

    if ((i % SPS) == 0) begin : g_first
      assign cin = stage_cin[K];
    end else begin : g_chain
      assign cin = g_sl[i-1].cout;
    end

    if ((i % SPS) == (SPS - 1)) begin : g_cout
      assign c_d[K] = cout;
    end

    csa_slice #(.BLOCK(BLOCK)) u_slice (
      .a    (a_d[K][i*BLOCK +: BLOCK]),
      .b    (b_d[K][i*BLOCK +: BLOCK]),
      .cin  (cin),
      .sum  (sum),
      .cout (cout)
    );

    // Slices below this stage pass finished bits down; slices above it are not yet known.
    for (genvar k = 0; k < STAGES; k++) begin : g_res
      if (k == K) begin : g_own
        assign res_d[k][i*BLOCK +: BLOCK] = sum;
      end else if (k > K) begin : g_done
        assign res_d[k][i*BLOCK +: BLOCK] = res_q[k-1][i*BLOCK +: BLOCK];
      end else begin : g_todo
        assign res_d[k][i*BLOCK +: BLOCK] = '0;
      end
    end
  end

  always_comb begin
    res_fin = res_d[LAST];
    ovf_d   = (am_d[LAST] == bm_d[LAST]) && (res_fin[WIDTH-1] != am_d[LAST]);
    ne_d    = |res_fin;
    lt_d    = ovf_d ? am_d[LAST] : res_fin[WIDTH-1];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q   <= '0;
      c_q   <= '0;
      am_q  <= '0;
      bm_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      ne_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      ne_q  <= ne_d;
      lt_q  <= lt_d;
    end
  end

  assign out_valid  = v_q[LAST];
  assign out        = res_q[LAST];
  assign carry_out  = c_q[LAST];
  assign overflow   = ovf_q;
  assign isNotEqual = ne_q;
  assign isLessThan = lt_q;

  // Operand bits already consumed by earlier slices, and the last stage's copies, are never read.
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, am_q, bm_q, res_q};

endmodule

// File: tb/tb_pipe_csa_addsub.sv
// tb/tb_pipe_csa_addsub.sv - directed table and sequence checks for pipe_csa_addsub
module tb_pipe_csa_addsub;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in0, in1;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        carry_out, overflow, isNotEqual, isLessThan;

  logic [15:0] s_in0, s_in1;
  logic        s_sub, s_valid;
  logic [2:0]  s_rdy, s_vld, s_c, s_ov, s_ne, s_lt;
  logic [15:0] s_out [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipe_csa_addsub #(.WIDTH(32), .BLOCK(8), .STAGES(2)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in0(in0), .in1(in1), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry_out(carry_out), .overflow(overflow),
    .isNotEqual(isNotEqual), .isLessThan(isLessThan)
  );

  for (genvar g = 0; g < 3; g++) begin : g_sw
    pipe_csa_addsub #(.WIDTH(16), .BLOCK(4), .STAGES(1 << g)) u_sw (
      .clock(clock), .reset(reset), .in_valid(s_valid), .in_ready(s_rdy[g]),
      .in0(s_in0), .in1(s_in1), .sub(s_sub), .out_valid(s_vld[g]), .out_ready(1'b1),
      .out(s_out[g]), .carry_out(s_c[g]), .overflow(s_ov[g]),
      .isNotEqual(s_ne[g]), .isLessThan(s_lt[g])
    );
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] out;
    logic        c;
    logic        ov;
    logic        ne;
    logic        lt;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_a [8];
    logic [31:0] bp_b [8];
    logic        bp_s [8];
    logic [31:0] held;
    int          sent, recv, cy, stall_n;

    tbl[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{32'h0000_0009, 32'h0000_0009, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{32'h00FF_00FF, 32'h0001_FF01, 1'b0, 32'h0101_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; sub = 1'b0; out_ready = 1'b0;
    s_in0 = '0; s_in1 = '0; s_sub = 1'b0; s_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out", out, 0);
    chk("reset flags", {carry_out, overflow, isNotEqual, isLessThan}, 0);
    chk("reset in_ready", in_ready, 1);

    // Single ops, latency two cycles from presentation.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      in_valid = 1'b1; in0 = tbl[i].a; in1 = tbl[i].b; sub = tbl[i].sub;
      @(negedge clock);
      in_valid = 1'b0;
      chk($sformatf("v%0d early valid", i), out_valid, 0);
      @(negedge clock);
      chk($sformatf("v%0d valid", i), out_valid, 1);
      chk($sformatf("v%0d out", i), out, tbl[i].out);
      chk($sformatf("v%0d carry", i), carry_out, tbl[i].c);
      chk($sformatf("v%0d overflow", i), overflow, tbl[i].ov);
      chk($sformatf("v%0d ne", i), isNotEqual, tbl[i].ne);
      chk($sformatf("v%0d lt", i), isLessThan, tbl[i].lt);
    end

    // Back-to-back stream with a three-cycle consumer stall.
    for (int j = 0; j < 8; j++) begin
      bp_a[j] = 32'h1111_1111 * j + 32'h0F0F_0F0F;
      bp_b[j] = 32'h0123_4567 ^ j;
      bp_s[j] = j[0];
    end
    sent = 0; recv = 0; cy = 0; stall_n = 0; held = '0;
    while (recv < 8 && cy < 60) begin
      @(negedge clock);
      out_ready = !(cy >= 4 && cy < 7);
      in_valid = (sent < 8);
      in0 = bp_a[sent % 8]; in1 = bp_b[sent % 8]; sub = bp_s[sent % 8];
      #1;
      if (!out_ready) begin
        chk("stall in_ready", in_ready, 0);
        chk("stall out_valid", out_valid, 1);
        if (stall_n > 0) chk("stall out stable", out, held);
        held = out;
        stall_n++;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("stream r%0d", recv), out,
            bp_s[recv] ? bp_a[recv] - bp_b[recv] : bp_a[recv] + bp_b[recv]);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      cy++;
    end
    chk("stream received", recv, 8);
    chk("stream sent", sent, 8);
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clock);
    chk("stream drained", out_valid, 0);

    // Reset with two ops in flight, and a third presented during reset.
    @(negedge clock);
    in_valid = 1'b1; in0 = 32'd5; in1 = 32'd7; sub = 1'b1;
    @(negedge clock);
    in0 = 32'd100; in1 = 32'd1; sub = 1'b0;
    @(negedge clock);
    chk("pre-reset valid", out_valid, 1);
    reset = 1'b1; in0 = 32'd40; in1 = 32'd2;
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    chk("mid reset valid", out_valid, 0);
    chk("mid reset out", out, 0);
    chk("mid reset flags", {carry_out, overflow, isNotEqual, isLessThan}, 0);
    @(negedge clock);
    chk("post reset no ghost 1", out_valid, 0);
    @(negedge clock);
    chk("post reset no ghost 2", out_valid, 0);
    in_valid = 1'b1; in0 = 32'h1234_5678; in1 = 32'h1111_1111; sub = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("post reset early", out_valid, 0);
    @(negedge clock);
    chk("post reset valid", out_valid, 1);
    chk("post reset out", out, 32'h0123_4567);

    // 16-bit sweep over STAGES = 1, 2, 4 against a signed-arithmetic model.
    for (int v = 0; v < 10; v++) begin
      int          sa, sb, exact;
      int unsigned ua, ub;
      logic        e_c;
      @(negedge clock);
      s_in0 = 16'($urandom); s_in1 = 16'($urandom); s_sub = 1'($urandom_range(0, 1));
      if (v == 0) begin s_in0 = 16'h8000; s_in1 = 16'h0001; s_sub = 1'b1; end
      if (v == 1) begin s_in0 = 16'h7FFF; s_in1 = 16'h0001; s_sub = 1'b0; end
      if (v == 2) begin s_in0 = 16'hFFFF; s_in1 = 16'h0001; s_sub = 1'b0; end
      sa = int'($signed(s_in0)); sb = int'($signed(s_in1));
      ua = int'(s_in0); ub = int'(s_in1);
      exact = s_sub ? sa - sb : sa + sb;
      e_c = s_sub ? (ua >= ub) : ((ua + ub) > 32'hFFFF);
      s_valid = 1'b1;
      for (int c = 1; c <= 4; c++) begin
        @(negedge clock);
        s_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
          chk($sformatf("sw%0d st%0d c%0d valid", v, 1 << g, c), s_vld[g], (c == (1 << g)));
          if (c == 1) chk($sformatf("sw%0d st%0d ready", v, 1 << g), s_rdy[g], 1);
          if (c == (1 << g)) begin
            chk($sformatf("sw%0d st%0d out", v, 1 << g), s_out[g], exact[15:0]);
            chk($sformatf("sw%0d st%0d carry", v, 1 << g), s_c[g], e_c);
            chk($sformatf("sw%0d st%0d ov", v, 1 << g), s_ov[g], (exact > 32767 || exact < -32768));
            chk($sformatf("sw%0d st%0d ne", v, 1 << g), s_ne[g], (exact[15:0] != 16'h0));
            chk($sformatf("sw%0d st%0d lt", v, 1 << g), s_lt[g], (exact < 0));
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
